// File: rtl/cholesky_scheduler_if.sv
// ============================================================================
// Module      : cholesky_scheduler_if
// Description : Bundle of the requester, result and core-side signals of the
//               cholesky_scheduler.
//               slave  - modport used by the scheduler.
//               master - modport used by the surrounding environment
//                        (requesters, result sink and the cholesky core).
// Signals     : req0_valid/req0_ready/req0_A, req1_valid/req1_ready/req1_A
//               res_valid/res_ready/res_L/res_id/res_err
//               core_rst/core_A/core_A_valid/core_L/core_L_valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cholesky_scheduler_if #(
    parameter int DATA_W = 480
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_A;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_A;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_L;
    logic              res_id;
    logic              res_err;
    logic              core_rst;
    logic [DATA_W-1:0] core_A;
    logic              core_A_valid;
    logic [DATA_W-1:0] core_L;
    logic              core_L_valid;

    modport slave (
        input  req0_valid, req0_A, req1_valid, req1_A, res_ready,
               core_L, core_L_valid,
        output req0_ready, req1_ready, res_valid, res_L, res_id, res_err,
               core_rst, core_A, core_A_valid
    );

    modport master (
        output req0_valid, req0_A, req1_valid, req1_A, res_ready,
               core_L, core_L_valid,
        input  req0_ready, req1_ready, res_valid, res_L, res_id, res_err,
               core_rst, core_A, core_A_valid
    );
endinterface

`default_nettype wire

// File: rtl/cholesky_scheduler.sv
// ============================================================================
// Module      : cholesky_scheduler
// Description : Shares one cholesky core between two covariance requesters.
//               Round-robin arbitration, loads the granted packed matrix into
//               the core for HOLD_CYCLES enabled cycles, waits for the factor
//               and returns it tagged with the requester ID.
//               Optional watchdog enabled by defining CHOL_SCHED_WATCHDOG_EN:
//               aborts a job after TIMEOUT enabled LOAD/WAIT cycles, pulses
//               core_rst for 2 cycles and returns an error result.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               clk_en_i - global enable; all state holds while low
//               busy_o   - high in any state other than IDLE
//               bus      - cholesky_scheduler_if.slave (requests, result,
//                          core load/result signals)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cholesky_scheduler #(
    parameter int DATA_W      = 480,
    parameter int HOLD_CYCLES = 10,
    parameter int TIMEOUT     = 1023
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  clk_en_i,
    output logic busy_o,
    cholesky_scheduler_if.slave bus
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef CHOL_SCHED_WATCHDOG_EN
    localparam logic [2:0] S_FLUSH = 3'd4;
`endif

    // Elaboration-time parameter sanity checks
    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("cholesky_scheduler: TIMEOUT out of range 16..65535");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("cholesky_scheduler: HOLD_CYCLES must be at least 1");
    end

    logic [2:0]        state_q,    state_d;
    logic              last_id_q,  last_id_d;
    logic              id_q,       id_d;
    logic [DATA_W-1:0] core_a_q,   core_a_d;
    logic [DATA_W-1:0] res_l_q,    res_l_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_rst_q, core_rst_d;
`ifdef CHOL_SCHED_WATCHDOG_EN
    logic [15:0]       wd_cnt_q,    wd_cnt_d;
    logic              flush_cnt_q, flush_cnt_d;
    logic              res_err_q,   res_err_d;
    logic              wd_expire;
`endif

    logic grant0, grant1, accept0, accept1;

    // Round-robin: a lone requester wins; on a tie the one that was not
    // served last wins (last_id resets to 1 so req0 wins the first tie).
    assign grant0  = bus.req0_valid & (~bus.req1_valid | last_id_q);
    assign grant1  = bus.req1_valid & (~bus.req0_valid | ~last_id_q);
    assign accept0 = bus.req0_valid & bus.req0_ready;
    assign accept1 = bus.req1_valid & bus.req1_ready;

`ifdef CHOL_SCHED_WATCHDOG_EN
    // Expiry on the enabled edge that completes the TIMEOUT-th LOAD/WAIT cycle
    assign wd_expire = (wd_cnt_q == 16'(TIMEOUT - 1));
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            core_a_q    <= '0;
            res_l_q     <= '0;
            hold_cnt_q  <= '0;
            core_rst_q  <= 1'b1;
`ifdef CHOL_SCHED_WATCHDOG_EN
            wd_cnt_q    <= '0;
            flush_cnt_q <= 1'b0;
            res_err_q   <= 1'b0;
`endif
        end else if (clk_en_i) begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            id_q        <= id_d;
            core_a_q    <= core_a_d;
            res_l_q     <= res_l_d;
            hold_cnt_q  <= hold_cnt_d;
            core_rst_q  <= core_rst_d;
`ifdef CHOL_SCHED_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        id_d       = id_q;
        core_a_d   = core_a_q;
        res_l_d    = res_l_q;
        hold_cnt_d = hold_cnt_q;
        core_rst_d = 1'b0;          // the power-on core reset drops on the first enabled edge
`ifdef CHOL_SCHED_WATCHDOG_EN
        wd_cnt_d    = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
        flush_cnt_d = flush_cnt_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CHOL_SCHED_WATCHDOG_EN
                wd_cnt_d = wd_cnt_q;
`endif
                if (accept0 | accept1) begin
                    state_d    = S_LOAD;
                    id_d       = accept1;
                    core_a_d   = accept1 ? bus.req1_A : bus.req0_A;
                    hold_cnt_d = '0;
`ifdef CHOL_SCHED_WATCHDOG_EN
                    wd_cnt_d   = '0;
`endif
                end
            end
            S_LOAD, S_WAIT: begin
                // A result always beats watchdog expiry and the load window
                if (bus.core_L_valid) begin
                    state_d   = S_DONE;
                    res_l_d   = bus.core_L;
`ifdef CHOL_SCHED_WATCHDOG_EN
                    res_err_d = 1'b0;
                end else if (wd_expire) begin
                    state_d     = S_FLUSH;
                    core_rst_d  = 1'b1;
                    flush_cnt_d = 1'b0;
`endif
                end else if (state_q == S_LOAD) begin
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_d = S_WAIT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            S_DONE: begin
`ifdef CHOL_SCHED_WATCHDOG_EN
                wd_cnt_d = wd_cnt_q;
`endif
                if (bus.res_ready) begin
                    last_id_d = id_q;
                    state_d   = S_IDLE;
                end
            end
`ifdef CHOL_SCHED_WATCHDOG_EN
            S_FLUSH: begin
                wd_cnt_d = wd_cnt_q;
                // core_rst is already high for the first FLUSH cycle; keep it
                // for one more, then report the aborted job.
                if (flush_cnt_q) begin
                    state_d   = S_DONE;
                    res_l_d   = '0;
                    res_err_d = 1'b1;
                end else begin
                    core_rst_d  = 1'b1;
                    flush_cnt_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.req0_ready   = 1'b0;
        bus.req1_ready   = 1'b0;
        bus.core_A_valid = 1'b0;
        bus.res_valid    = 1'b0;
        busy_o           = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                // rst_n term keeps ready low while reset is held
                bus.req0_ready = rst_n & clk_en_i & grant0;
                bus.req1_ready = rst_n & clk_en_i & grant1;
            end
            S_LOAD:  bus.core_A_valid = 1'b1;
            S_DONE:  bus.res_valid    = 1'b1;
            default: ;
        endcase
    end

    assign bus.core_A   = core_a_q;
    assign bus.core_rst = core_rst_q;
    assign bus.res_L    = res_l_q;
    assign bus.res_id   = id_q;
`ifdef CHOL_SCHED_WATCHDOG_EN
    assign bus.res_err  = res_err_q;
`else
    assign bus.res_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cholesky_scheduler.sv
// ============================================================================
// Module      : tb_cholesky_scheduler
// Description : Self-checking bench for cholesky_scheduler. Requester queues
//               drive the request ports, a behavioural core answers each load
//               with ~A after a fixed enabled-cycle latency, and a scoreboard
//               of expected results is filled on every accept and drained on
//               every result handshake. The watchdog scenario only runs when
//               CHOL_SCHED_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cholesky_scheduler;

    localparam int DW   = 480;
    localparam int HOLD = 10;
    localparam int TO   = 64;

    typedef struct packed {
        logic          id;
        logic          err;
        logic [DW-1:0] l;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic clk_en = 1'b0;
    logic busy;

    cholesky_scheduler_if #(.DATA_W(DW)) bus ();

    cholesky_scheduler #(
        .DATA_W      (DW),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TO)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en_i (clk_en),
        .busy_o   (busy),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    exp_t          sb[$];
    int            grant_log[$];
    logic          acc0 = 1'b0;
    logic          acc1 = 1'b0;
    logic          core_mute = 1'b0;
    int            core_lat  = 40;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mat(input int seed);
        logic [DW-1:0] m;
        for (int w = 0; w < 15; w++)
            m[w*32 +: 32] = 32'(seed) * 32'h0101_0000 + 32'(w) * 32'h0000_1234 + 32'h0000_000a;
        return m;
    endfunction

    // Reference matrix: word 0 = 0x00190000 ... word 14 = 0x000a0000
    function automatic logic [DW-1:0] ref_mat();
        logic [DW-1:0] m;
        for (int w = 0; w < 15; w++)
            m[w*32 +: 32] = (w == 14) ? 32'h000a_0000 : (32'h19 - 32'(w)) << 16;
        return m;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n >= budget), 1'b0);
    endtask

    // Requester drivers
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_A     = '0;
        forever begin
            step();
            if (acc0) void'(q0.pop_front());
            bus.req0_valid = (q0.size() != 0);
            bus.req0_A     = (q0.size() != 0) ? q0[0] : '0;
        end
    end

    initial begin
        bus.req1_valid = 1'b0;
        bus.req1_A     = '0;
        forever begin
            step();
            if (acc1) void'(q1.pop_front());
            bus.req1_valid = (q1.size() != 0);
            bus.req1_A     = (q1.size() != 0) ? q1[0] : '0;
        end
    end

    // Accept monitor: pushes the expected result for every accepted request
    initial begin
        int run0 = 0;
        int run1 = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            acc0 = rst_n & bus.req0_valid & bus.req0_ready;
            acc1 = rst_n & bus.req1_valid & bus.req1_ready;
            if (bus.req0_ready || bus.req1_ready)
                chk("ready_onehot", bus.req0_ready & bus.req1_ready, 1'b0);
            if (acc0 || acc1) begin
                e.id  = acc1;
                e.err = core_mute;
                e.l   = core_mute ? '0 : ~(acc1 ? bus.req1_A : bus.req0_A);
                sb.push_back(e);
                grant_log.push_back(acc1 ? 1 : 0);
            end
            if (bus.req0_ready) run0++;
            else begin
                if (run0 > 0) chk("ready0_pulse_len", run0, 1);
                run0 = 0;
            end
            if (bus.req1_ready) run1++;
            else begin
                if (run1 > 0) chk("ready1_pulse_len", run1, 1);
                run1 = 0;
            end
        end
    end

    // Behavioural core: answers ~A core_lat enabled cycles after load start
    initial begin
        logic          prev_av = 1'b0;
        logic          prev_en = 1'b0;
        logic          pending = 1'b0;
        logic [DW-1:0] cur_a   = '0;
        int            e_cnt   = 0;
        int            av_len  = 0;
        bus.core_L_valid = 1'b0;
        bus.core_L       = '0;
        forever begin
            @(negedge clk);
            if (bus.core_L_valid && prev_en) bus.core_L_valid = 1'b0;
            if (bus.core_A_valid && !prev_av) begin
                cur_a   = bus.core_A;
                e_cnt   = 0;
                av_len  = 0;
                pending = !core_mute;
            end
            if (bus.core_A_valid && clk_en) av_len++;
            if (!bus.core_A_valid && prev_av) chk("a_valid_len", av_len, HOLD);
            if (pending && clk_en) begin
                e_cnt++;
                if (e_cnt == core_lat) begin
                    bus.core_L_valid = 1'b1;
                    bus.core_L       = ~cur_a;
                    pending          = 1'b0;
                end
            end
            prev_av = bus.core_A_valid;
            prev_en = clk_en;
        end
    end

    // Result monitor: pops the scoreboard on each result handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && clk_en && bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("res_id",  bus.res_id,  e.id);
                    chk("res_err", bus.res_err, e.err);
                    chk("res_L",   bus.res_L,   e.l);
                end
            end
        end
    end

    initial begin
        int   cyc;
        int   n;
        logic seen;
        bus.res_ready = 1'b1;

        // ---------------- reset values ----------------
        clk_en = 1'b1;
        #2 rst_n = 1'b0;
        q0.push_back(ref_mat());
        step();
        step();
        @(negedge clk);
        chk("rst_res_valid",    bus.res_valid,    1'b0);
        chk("rst_res_L",        bus.res_L,        '0);
        chk("rst_res_id",       bus.res_id,       1'b0);
        chk("rst_res_err",      bus.res_err,      1'b0);
        chk("rst_core_A",       bus.core_A,       '0);
        chk("rst_core_A_valid", bus.core_A_valid, 1'b0);
        chk("rst_busy",         busy,             1'b0);
        chk("rst_core_rst",     bus.core_rst,     1'b1);
        chk("rst_req0_ready",   bus.req0_ready,   1'b0);

        // Release with clk_en low: everything holds, including core_rst
        step();
        clk_en = 1'b0;
        rst_n  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_core_rst",    bus.core_rst,   1'b1);
            chk("hold_req0_ready",  bus.req0_ready, 1'b0);
        end
        step();
        clk_en = 1'b1;
        @(negedge clk);
        chk("en_return_ready0", bus.req0_ready, 1'b1);
        @(negedge clk);
        chk("core_rst_cleared", bus.core_rst, 1'b0);
        chk("busy_after_accept", busy, 1'b1);

        // ---------------- single job (reference matrix) ----------------
        wait_drain(300);

        // ---------------- lone req1 ----------------
        step();
        q1.push_back(mat(1));
        wait_drain(300);

        // ---------------- contention: 0,1,0,1 ----------------
        step();
        grant_log.delete();
        q0.push_back(mat(2));
        q0.push_back(mat(3));
        q1.push_back(mat(4));
        q1.push_back(mat(5));
        wait_drain(800);
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), grant_log[i], i % 2);

        // ---------------- backpressure ----------------
        step();
        bus.res_ready = 1'b0;
        q0.push_back(mat(6));
        n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_timeout", (n >= 200), 1'b0);
        step();
        q1.push_back(mat(7));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_res_valid", bus.res_valid, 1'b1);
            chk("bp_busy",      busy,          1'b1);
            chk("bp_req1_ready", bus.req1_ready, 1'b0);
            if (sb.size() != 0) begin
                chk("bp_res_L_stable",  bus.res_L,  sb[0].l);
                chk("bp_res_id_stable", bus.res_id, sb[0].id);
            end
        end
        step();
        bus.res_ready = 1'b1;
        wait_drain(300);

        // ---------------- clk_en gap ----------------
        step();
        clk_en = 1'b0;
        q1.push_back(mat(8));
        repeat (3) begin
            @(negedge clk);
            chk("gap_idle_ready1", bus.req1_ready, 1'b0);
        end
        step();
        clk_en = 1'b1;
        n = 0;
        while (!bus.core_A_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("gap_load_timeout", (n >= 20), 1'b0);
        repeat (3) step();
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("gap_a_valid_held", bus.core_A_valid, 1'b1);
            step();
        end
        clk_en = 1'b1;
        wait_drain(300);

`ifdef CHOL_SCHED_WATCHDOG_EN
        // ---------------- watchdog ----------------
        step();
        core_mute = 1'b1;
        q0.push_back(mat(9));
        cyc = 0;
        while (!busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        // First busy negedge is job cycle 1; expiry happens on edge
        // accept+TO so core_rst becomes visible in job cycle TO+1.
        cyc = 1;
        while (!bus.core_rst && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("wd_rst_start", cyc, TO + 1);
        n = 0;
        while (bus.core_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("wd_rst_len", n, 2);
        wait_drain(100);
        core_mute = 1'b0;
        step();
        q1.push_back(mat(10));
        wait_drain(300);
`endif

        // ---------------- reset mid-WAIT ----------------
        step();
        q1.push_back(mat(11));
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid",    bus.res_valid,    1'b0);
        chk("mid_rst_busy",         busy,             1'b0);
        chk("mid_rst_core_A_valid", bus.core_A_valid, 1'b0);
        chk("mid_rst_core_A",       bus.core_A,       '0);
        chk("mid_rst_core_rst",     bus.core_rst,     1'b1);
        chk("mid_rst_res_id",       bus.res_id,       1'b0);
        chk("mid_rst_res_L",        bus.res_L,        '0);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.res_valid || busy) seen = 1'b1;
        end
        chk("no_late_result", seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global safety net
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
